// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit that owns the HI/LO registers.
// Multiply is shift-add and divide is restoring. Both retire one bit per
// cycle, so every MULT/DIV takes 32 cycles from the accepting edge to the
// commit edge. Signed operations run on magnitudes and are sign-corrected
// as they are written into HI/LO.
module alu_muldiv (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [5:0]  i_control,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_t;

    state_t      state;
    state_t      state_next;

    // Iteration state. The multiply and divide share one working register:
    //   multiply: work = {partial product high half, remaining multiplier bits}
    //   divide:   work = {partial remainder, dividend bits / quotient bits}
    logic [4:0]  iter_cnt;
    logic [63:0] work;
    logic [31:0] operand;     // multiplicand magnitude or divisor magnitude
    logic        neg_lo;      // negate product (mul) or quotient (div) on commit
    logic        neg_hi;      // negate remainder on commit
    logic        div_zero;    // divisor was zero when the divide was accepted

    // Decode and step signals
    logic        is_mul;
    logic        is_div;
    logic        op_signed;
    logic        idle;
    logic        accept_mul;
    logic        accept_div;
    logic        load_hi;
    logic        load_lo;
    logic [31:0] abs_op1;
    logic [31:0] abs_op2;
    logic        sign_diff;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic        last_iter;
    logic        commit;

    logic [63:0] prod_final;
    logic [31:0] quo_final;
    logic [31:0] rem_final;

    // Function decode and operand magnitudes
    always_comb begin
        is_mul     = (i_control == FN_MULT) || (i_control == FN_MULTU);
        is_div     = (i_control == FN_DIV)  || (i_control == FN_DIVU);
        // MULT/DIV have bit 0 clear, the unsigned forms have it set.
        op_signed  = ~i_control[0];
        idle       = (state == ST_IDLE);
        accept_mul = idle && i_start && is_mul;
        accept_div = idle && i_start && is_div;
        load_hi    = idle && i_start && (i_control == FN_MTHI);
        load_lo    = idle && i_start && (i_control == FN_MTLO);
        abs_op1    = (op_signed && i_op1[31]) ? -i_op1 : i_op1;
        abs_op2    = (op_signed && i_op2[31]) ? -i_op2 : i_op2;
        sign_diff  = op_signed && (i_op1[31] ^ i_op2[31]);
    end

    // One iteration of shift-add multiply and of restoring divide
    always_comb begin
        mul_sum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand} : 33'd0);
        mul_next  = {mul_sum, work[31:1]};

        div_shift = {work[63:32], work[31]};
        div_diff  = div_shift - {1'b0, operand};
        // The remainder stays below the divisor, so a set bit 32 of the
        // difference can only mean it went negative: restore in that case.
        if (div_diff[32])
            div_next = {div_shift[31:0], work[30:0], 1'b0};
        else
            div_next = {div_diff[31:0], work[30:0], 1'b1};

        last_iter = (iter_cnt == 5'd31);
        commit    = (state != ST_IDLE) && last_iter;
    end

    // Sign-corrected values written into HI/LO on the commit edge
    always_comb begin
        prod_final = neg_lo ? -mul_next : mul_next;
        rem_final  = neg_hi ? -div_next[63:32] : div_next[63:32];
        // With a zero divisor every trial subtraction succeeds, which leaves
        // the dividend magnitude as the remainder; sign correction then
        // reproduces the original dividend, so only LO needs forcing.
        if (div_zero)
            quo_final = '1;
        else
            quo_final = neg_lo ? -div_next[31:0] : div_next[31:0];
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_mul)
                    state_next = ST_MUL;
                else if (accept_div)
                    state_next = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (last_iter)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_busy = (state == ST_MUL) || (state == ST_DIV);
    end

    // Datapath: operand latch, iteration, HI/LO commit and move-to loads
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            iter_cnt <= '0;
            work     <= '0;
            operand  <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            o_hi     <= '0;
            o_lo     <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= commit;
            case (state)
                ST_IDLE: begin
                    if (accept_mul) begin
                        iter_cnt <= '0;
                        work     <= {32'd0, abs_op2};
                        operand  <= abs_op1;
                        neg_lo   <= sign_diff;
                        neg_hi   <= 1'b0;
                        div_zero <= 1'b0;
                    end else if (accept_div) begin
                        iter_cnt <= '0;
                        work     <= {32'd0, abs_op1};
                        operand  <= abs_op2;
                        neg_lo   <= sign_diff;
                        neg_hi   <= op_signed && i_op1[31];
                        div_zero <= (i_op2 == 32'd0);
                    end
                    if (load_hi)
                        o_hi <= i_op1;
                    if (load_lo)
                        o_lo <= i_op1;
                end
                ST_MUL: begin
                    work     <= mul_next;
                    iter_cnt <= iter_cnt + 5'd1;
                    if (last_iter) begin
                        o_hi <= prod_final[63:32];
                        o_lo <= prod_final[31:0];
                    end
                end
                ST_DIV: begin
                    work     <= div_next;
                    iter_cnt <= iter_cnt + 5'd1;
                    if (last_iter) begin
                        o_hi <= rem_final;
                        o_lo <= quo_final;
                    end
                end
                default: begin
                    iter_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vector table, hand-written multi-cycle sequences
// and a random phase checked against a 64-bit arithmetic reference model.
module tb_alu_muldiv;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [5:0]  i_control;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_fail   = 0;

    alu_muldiv dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_control (i_control),
        .i_op1     (i_op1),
        .i_op2     (i_op2),
        .o_hi      (o_hi),
        .o_lo      (o_lo),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one MULT/DIV, check latency, hold of HI/LO, done pulse and result.
    // With b2b set the task starts at the current negedge (the done cycle of
    // the previous operation) instead of waiting for the next one.
    task automatic do_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit b2b, input string name);
        logic [63:0] prev;
        int cyc;
        bit held;
        if (!b2b) @(negedge i_clk);
        prev      = {o_hi, o_lo};
        i_control = c;
        i_op1     = a;
        i_op2     = b;
        i_start   = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        i_op1   = $urandom;
        i_op2   = $urandom;
        cyc  = 0;
        held = 1'b1;
        while (o_busy === 1'b1 && cyc < 40) begin
            cyc++;
            if ({o_hi, o_lo} !== prev) held = 1'b0;
            @(negedge i_clk);
        end
        chk({name, " latency"}, 64'(cyc), 64'd32);
        chk({name, " hold"}, 64'(held), 64'd1);
        chk({name, " done"}, 64'(o_done), 64'd1);
        chk({name, " hilo"}, {o_hi, o_lo}, exp);
    endtask

    function automatic logic [63:0] ref_model(input logic [5:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        logic [31:0] uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (c)
            FN_MULT:  return 64'(sa * sb);
            FN_MULTU: return ua * ub;
            FN_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                uq = a / b;
                ur = a % b;
                return {ur, uq};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h80000000;
            1: return 32'h00000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        logic [5:0]  rc;
        logic [31:0] ra, rb;

        vecs[0]  = '{FN_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{FN_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[6]  = '{FN_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        vecs[7]  = '{FN_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[8]  = '{FN_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[9]  = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{FN_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[11] = '{FN_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[12] = '{FN_MULT,  32'h00012345, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[13] = '{FN_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[14] = '{FN_DIV,   32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000};
        vecs[15] = '{FN_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};

        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_control = '0;
        i_op1     = '0;
        i_op2     = '0;

        // Reset state
        @(negedge i_clk);
        chk("reset hi", 64'(o_hi), 64'd0);
        chk("reset lo", 64'(o_lo), 64'd0);
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset done", 64'(o_done), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Start accepted on the first edge after reset release
        do_op(FN_MULT, 32'hFFFFFFFE, 32'h3, 64'hFFFFFFFF_FFFFFFFA, 1'b1, "first_mult");
        @(negedge i_clk);
        chk("done one cycle", 64'(o_done), 64'd0);
        chk("result held", {o_hi, o_lo}, 64'hFFFFFFFF_FFFFFFFA);

        // MTHI / MTLO in IDLE
        i_control = FN_MTHI;
        i_op1     = 32'h12345678;
        i_start   = 1'b1;
        @(posedge i_clk);
        #1;
        chk("mthi hi", 64'(o_hi), 64'h12345678);
        chk("mthi busy", 64'(o_busy), 64'd0);
        @(negedge i_clk);
        chk("mthi done", 64'(o_done), 64'd0);
        chk("mthi lo kept", 64'(o_lo), 64'hFFFFFFFA);
        i_control = FN_MTLO;
        i_op1     = 32'h0BADF00D;
        @(posedge i_clk);
        #1;
        chk("mtlo hilo", {o_hi, o_lo}, 64'h12345678_0BADF00D);
        @(negedge i_clk);

        // Unrelated function code is ignored
        i_control = 6'b100000;
        i_op1     = 32'hAAAA5555;
        i_op2     = 32'h00000003;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("ignored hilo", {o_hi, o_lo}, 64'h12345678_0BADF00D);
        chk("ignored busy", 64'(o_busy), 64'd0);

        // Directed table; odd entries are issued in the done cycle of the previous one
        for (int i = 0; i < 16; i++)
            do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo},
                  (i % 2) == 1, $sformatf("vec%0d", i));

        // Requests while busy (MTLO, then MULT) must be ignored
        @(negedge i_clk);
        i_control = FN_MULTU;
        i_op1     = 32'd3;
        i_op2     = 32'd4;
        i_start   = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        cyc = 0;
        while (o_busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (cyc == 5) begin
                i_control = FN_MTLO;
                i_op1     = 32'hDEADBEEF;
                i_start   = 1'b1;
            end else if (cyc == 6) begin
                i_control = FN_MULT;
                i_op1     = 32'd9;
                i_op2     = 32'd9;
            end else if (cyc == 7) begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        chk("busy_ign latency", 64'(cyc), 64'd32);
        chk("busy_ign hilo", {o_hi, o_lo}, 64'd12);
        chk("busy_ign done", 64'(o_done), 64'd1);
        @(negedge i_clk);
        chk("busy_ign no requeue", 64'(o_busy), 64'd0);
        chk("busy_ign done low", 64'(o_done), 64'd0);

        // Reset during cycle 10 of a DIV aborts it
        i_control = FN_DIV;
        i_op1     = 32'd100;
        i_op2     = 32'd7;
        i_start   = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("async rst hilo", {o_hi, o_lo}, 64'd0);
        chk("async rst busy", 64'(o_busy), 64'd0);
        chk("async rst done", 64'(o_done), 64'd0);
        @(negedge i_clk);
        chk("rst hold done", 64'(o_done), 64'd0);
        @(negedge i_clk);
        chk("rst hold busy", 64'(o_busy), 64'd0);
        i_rst = 1'b0;
        do_op(FN_MULTU, 32'd5, 32'd6, 64'd30, 1'b1, "post_rst_multu");

        // Random operations against the reference model
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: rc = FN_MULT;
                1: rc = FN_MULTU;
                2: rc = FN_DIV;
                default: rc = FN_DIVU;
            endcase
            ra = pick_operand();
            rb = pick_operand();
            do_op(rc, ra, rb, ref_model(rc, ra, rb), 1'($urandom_range(0, 1)),
                  $sformatf("rnd%0d c=%b a=%h b=%h", k, rc, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
  i_clk  input  1  sole clock, rising edge
  i_rst  input  1  asynchronous, active-high reset
  i_start  input  1  request strobe, sampled on rising edge
  i_control  input  6  function code, same encoding as the ALU function field
  i_op1  input  32  rs value (multiplicand / dividend / MTHI/MTLO source)
  i_op2  input  32  rt value (multiplier / divisor)
  o_hi  output  32  HI register
  o_lo  output  32  LO register
  o_busy  output  1  multi-cycle operation in progress
  o_done  output  1  one-cycle pulse: HI/LO just committed by MULT/DIV
REQ-002 Function codes SHALL be: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
REQ-003 o_hi/o_lo SHALL be registered and feed the MFHI/MFLO leg of the execute result mux.

Function
REQ-004 FSM SHALL have states IDLE, MUL, DIV; reset state IDLE.
REQ-005 In IDLE, i_start with MULT/MULTU SHALL latch operands and go to MUL; with DIV/DIVU go to DIV.
REQ-006 In IDLE, i_start with MTHI SHALL load o_hi=i_op1 at that edge (MTLO: o_lo=i_op1); no busy, no done.
REQ-007 i_start with any other code SHALL be ignored (no state or register change).
REQ-008 i_start while o_busy=1 SHALL be ignored, including MTHI/MTLO; controller must stall.
REQ-009 o_busy SHALL be 1 exactly in MUL/DIV: 32 cycles, from the edge accepting i_start to the edge committing results.
REQ-010 Multiply SHALL be iterative shift-add, one multiplier bit per cycle, 32 iterations.
REQ-011 Divide SHALL be restoring, one quotient bit per cycle, 32 iterations.
REQ-012 Signed ops SHALL compute on magnitudes and sign-correct on commit; no extra cycle.
REQ-013 MULT/MULTU SHALL commit the full 64-bit product {o_hi,o_lo}; signed/unsigned per code.
REQ-014 DIV/DIVU SHALL commit o_lo=quotient, o_hi=remainder; signed quotient truncates toward zero, remainder takes dividend's sign.
REQ-015 Divisor 0 (DIV or DIVU) SHALL commit o_lo=32'hFFFFFFFF, o_hi=i_op1 as latched; same 32-cycle latency.
REQ-016 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL commit o_lo=32'h80000000, o_hi=0; no overflow flag.
REQ-017 Commit edge SHALL update o_hi/o_lo, return to IDLE, and set o_done=1 for the following cycle only.
REQ-018 i_start is accepted in the cycle o_done=1 (state is IDLE); back-to-back ops SHALL be 32 cycles apart.
REQ-019 o_hi/o_lo SHALL hold prior values throughout MUL/DIV; partial results never visible.
REQ-020 Operand inputs SHALL be don't-care after the accepting edge.

Reset
REQ-021 i_rst=1 SHALL immediately force IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, clearing all internal iteration state.
REQ-022 Reset during MUL/DIV SHALL abort the operation with no commit and no o_done pulse.
REQ-023 After i_rst deasserts, i_start SHALL be accepted on the first rising edge.

Verification
REQ-024 MULT op1=32'hFFFFFFFE (-2), op2=3 -> o_busy 32 cycles, then {o_hi,o_lo}=64'hFFFFFFFF_FFFFFFFA, o_done one cycle.
REQ-025 MULTU op1=op2=32'hFFFFFFFF -> o_hi=32'hFFFFFFFE, o_lo=32'h00000001.
REQ-026 DIV op1=-7, op2=2 -> o_lo=32'hFFFFFFFD (-3), o_hi=32'hFFFFFFFF (-1); DIVU op1=7, op2=0 -> o_lo=32'hFFFFFFFF, o_hi=7.
REQ-027 MTHI 32'h12345678 in IDLE -> o_hi updated next edge, o_busy=0; MTLO issued while busy -> o_lo unchanged.
REQ-028 Assert i_rst at cycle 10 of a DIV -> outputs 0 asynchronously, no o_done; new MULTU 5*6 afterward -> o_lo=30, o_hi=0 after 32 cycles.
REQ-029 Random signed/unsigned mult/div (incl. 32'h80000000, 0, -1 operands) SHALL match a reference model, with latency checked every op.
